// File: rtl/alu_dispatch_if.sv
// Instruction / ALU / writeback bundle between the dispatch stage and its
// surroundings. The slave side is the dispatcher; the master side is the
// instruction source plus the combinational ALU units feeding alu_result.
interface alu_dispatch_if #(
  parameter int DW = 8
);
  // Instruction handshake
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [1:0]    in_rd;
  logic [1:0]    in_rs1;
  logic [1:0]    in_rs2;
  logic [DW-1:0] in_imm;

  // Operand drive to the ALU units and their selected result
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;

  // Writeback report
  logic          wb_valid;
  logic [1:0]    wb_rd;
  logic [DW-1:0] wb_data;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, alu_result,
    input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, alu_result,
    output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/alu_dispatch.sv
// Sequential front end of the 8-bit execution datapath: accepts one
// instruction, reads two operands from a 4x8 register file, presents them to
// the external ALU units for one cycle, captures the result and writes it
// back. Load-immediate skips the ALU cycle. r0 reads as zero and ignores
// writes.
module alu_dispatch #(
  parameter int         NREGS  = 4,
  parameter int         DW     = 8,
  parameter logic [2:0] OP_LDI = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_dispatch_if.slave     bus,
  output logic              busy,
  input  logic [1:0]        dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [1:0]    rd_q, rd_d;
  logic [DW-1:0] res_q, res_d;

  // Register file contents as seen by operand and debug reads
  logic [DW-1:0] rf_w [NREGS];

  logic accept;
  logic wb_write;

  assign bus.in_ready = (state_q == S_IDLE) && rst_n;
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (state_q != S_IDLE);
  // Writeback happens on the edge that leaves WB, so the next accepted
  // instruction (at the earliest one edge later) always sees the new value.
  assign wb_write     = (state_q == S_WB);

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.wb_valid = (state_q == S_WB);
  assign bus.wb_rd    = rd_q;
  assign bus.wb_data  = res_q;

  assign dbg_data     = rf_w[dbg_addr];

  // Register file: r0 is a constant zero, r1..r3 are written from WB
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_w[gi] = '0;
      end else begin : g_reg
        logic [DW-1:0] r_q;
        // Capture the result when this register is the writeback target
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_q <= '0;
          end else if (wb_write && (rd_q == 2'(gi))) begin
            r_q <= res_q;
          end
        end
        assign rf_w[gi] = r_q;
      end
    end
  endgenerate

  // Next-state logic: latch on accept, capture ALU result in EXEC, retire in WB
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d  = rf_w[bus.in_rs1];
          alu_b_d  = rf_w[bus.in_rs2];
          alu_op_d = bus.in_op;
          rd_d     = bus.in_rd;
          if (bus.in_op == OP_LDI) begin
            res_d   = bus.in_imm;
            state_d = S_WB;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = bus.alu_result;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a behavioural ALU drives alu_result, and a plain
// array of register values predicts every writeback and debug read.
module tb_alu_dispatch;

  localparam logic [2:0] OP_LDI = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  alu_dispatch_if bus ();

  alu_dispatch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_rf [4];

  // External ALU units selected by opcode
  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a | b);
      3'b011:  return a ^ b;
      3'b100:  return a + b;
      3'b101:  return a - b;
      3'b110:  return ~(a & b);
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  // Present one instruction and return #1 after the edge that accepted it
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm);
    int waited;
    @(negedge clk);
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready still %b after %0d cycles, required 1", bus.in_ready, waited);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_imm = '0; dbg_addr = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
      n_checks++;
      if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b, required 0", bus.wb_valid); end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b, required 1", bus.in_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", busy); end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.wb_rd, bus.wb_data} !== 29'd0) begin
      n_fail++; $display("FAIL reset_outputs: alu_a=%h alu_b=%h alu_op=%0d wb_rd=%0d wb_data=%h, required all 0",
                         bus.alu_a, bus.alu_b, bus.alu_op, bus.wb_rd, bus.wb_data);
    end
    for (int i = 0; i < 4; i++) begin
      model_rf[i] = 8'h00;
      dbg_addr = 2'(i); #1;
      n_checks++;
      if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_dbg r%0d: got %h, required 00", i, dbg_data); end
    end
    $display("txn reset done");
  endtask

  task automatic test_ldi();
    logic [1:0] rds  [2] = '{2'd1, 2'd2};
    logic [7:0] imms [2] = '{8'h0F, 8'h33};
    for (int k = 0; k < 2; k++) begin
      send(OP_LDI, rds[k], 2'd0, 2'd0, imms[k]);
      n_checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== rds[k] || bus.wb_data !== imms[k]) begin
        n_fail++; $display("FAIL ldi_wb: got valid=%b rd=%0d data=%h, required 1 %0d %h",
                           bus.wb_valid, bus.wb_rd, bus.wb_data, rds[k], imms[k]);
      end
      n_checks++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL ldi_busy: got busy=%b ready=%b, required 1 0", busy, bus.in_ready);
      end
      @(posedge clk); #1;
      model_rf[rds[k]] = imms[k];
      n_checks++;
      if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL ldi_retire: got valid=%b ready=%b, required 0 1", bus.wb_valid, bus.in_ready);
      end
      dbg_addr = rds[k]; #1;
      n_checks++;
      if (dbg_data !== imms[k]) begin n_fail++; $display("FAIL ldi_dbg r%0d: got %h, required %h", rds[k], dbg_data, imms[k]); end
      $display("txn LDI r%0d=%h", rds[k], imms[k]);
    end
  endtask

  task automatic test_nor();
    send(OP_NOR, 2'd3, 2'd1, 2'd2, 8'h00);
    n_checks++;
    if (bus.alu_a !== 8'h0F || bus.alu_b !== 8'h33 || bus.alu_op !== OP_NOR) begin
      n_fail++; $display("FAIL nor_exec_operands: got a=%h b=%h op=%0d, required 0f 33 2", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    n_checks++;
    if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL nor_exec_wb_valid: got %b, required 0", bus.wb_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd3 || bus.wb_data !== 8'hC0) begin
      n_fail++; $display("FAIL nor_wb: got valid=%b rd=%0d data=%h, required 1 3 c0", bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL nor_wb_ready: got %b, required 0", bus.in_ready); end
    @(posedge clk); #1;
    model_rf[3] = 8'hC0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL nor_retire: got ready=%b valid=%b, required 1 0", bus.in_ready, bus.wb_valid);
    end
    dbg_addr = 2'd3; #1;
    n_checks++;
    if (dbg_data !== 8'hC0) begin n_fail++; $display("FAIL nor_dbg r3: got %h, required c0", dbg_data); end
    $display("txn NOR r3=r1,r2 -> %h", bus.wb_data);
  endtask

  task automatic test_r0();
    send(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hAA);
    n_checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd0 || bus.wb_data !== 8'hAA) begin
      n_fail++; $display("FAIL r0_wb: got valid=%b rd=%0d data=%h, required 1 0 aa", bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    @(posedge clk); #1;
    dbg_addr = 2'd0; #1;
    n_checks++;
    if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL r0_dbg: got %h, required 00", dbg_data); end
    $display("txn LDI r0=aa (dropped)");
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    bus.in_op = OP_NOR; bus.in_rd = 2'd1; bus.in_rs1 = 2'd1; bus.in_rs2 = 2'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_op = OP_LDI; bus.in_rd = 2'd2; bus.in_imm = 8'h55;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd1 || bus.wb_data !== 8'hF0) begin
          n_fail++; $display("FAIL b2b_first_wb: got valid=%b rd=%0d data=%h, required 1 1 f0",
                             bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
      end
    end while (!bus.in_ready && k < 10);
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL b2b_gap: second accept after %0d cycles, required 3", k); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_rf[1] = 8'hF0;
    n_checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 2'd2 || bus.wb_data !== 8'h55) begin
      n_fail++; $display("FAIL b2b_second_wb: got valid=%b rd=%0d data=%h, required 1 2 55", bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    @(posedge clk); #1;
    model_rf[2] = 8'h55;
    dbg_addr = 2'd1; #1;
    n_checks++;
    if (dbg_data !== 8'hF0) begin n_fail++; $display("FAIL b2b_dbg r1: got %h, required f0", dbg_data); end
    dbg_addr = 2'd2; #1;
    n_checks++;
    if (dbg_data !== 8'h55) begin n_fail++; $display("FAIL b2b_dbg r2: got %h, required 55", dbg_data); end
    $display("txn back-to-back NOR r1=r1,r1 / LDI r2=55 gap=%0d", k);
  endtask

  task automatic test_reset_mid();
    send(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h77);
    @(posedge clk); #1;
    dbg_addr = 2'd3; #1;
    n_checks++;
    if (dbg_data !== 8'h77) begin n_fail++; $display("FAIL mid_pre r3: got %h, required 77", dbg_data); end
    send(OP_NOR, 2'd3, 2'd1, 2'd2, 8'h00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.wb_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: got valid=%b busy=%b ready=%b, required 0 0 0", bus.wb_valid, busy, bus.in_ready);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_idle: got ready=%b valid=%b, required 1 0", bus.in_ready, bus.wb_valid);
    end
    for (int i = 0; i < 4; i++) begin
      model_rf[i] = 8'h00;
      dbg_addr = 2'(i); #1;
      n_checks++;
      if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL mid_dbg r%0d: got %h, required 00", i, dbg_data); end
    end
    $display("txn reset during EXEC");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm, expv;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7)); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
      imm = 8'($urandom);
      expv = (op == OP_LDI) ? imm : alu_ref(op, model_rf[rs1], model_rf[rs2]);
      send(op, rd, rs1, rs2, imm);
      if (op != OP_LDI) begin
        n_checks++;
        if (bus.alu_a !== model_rf[rs1] || bus.alu_b !== model_rf[rs2] || bus.alu_op !== op) begin
          n_fail++; $display("FAIL rnd_operands #%0d: got a=%h b=%h op=%0d, required %h %h %0d",
                             n, bus.alu_a, bus.alu_b, bus.alu_op, model_rf[rs1], model_rf[rs2], op);
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== rd || bus.wb_data !== expv) begin
        n_fail++; $display("FAIL rnd_wb #%0d: got valid=%b rd=%0d data=%h, required 1 %0d %h",
                           n, bus.wb_valid, bus.wb_rd, bus.wb_data, rd, expv);
      end
      @(posedge clk); #1;
      if (rd != 2'd0) model_rf[rd] = expv;
      n_checks++;
      if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_retire #%0d: got valid=%b ready=%b, required 0 1", n, bus.wb_valid, bus.in_ready);
      end
      dbg_addr = 2'($urandom); #1;
      n_checks++;
      if (dbg_data !== model_rf[dbg_addr]) begin
        n_fail++; $display("FAIL rnd_dbg #%0d r%0d: got %h, required %h", n, dbg_addr, dbg_data, model_rf[dbg_addr]);
      end
      $display("txn rnd #%0d op=%0d rd=%0d rs1=%0d rs2=%0d -> %h", n, op, rd, rs1, rs2, bus.wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_nor();
    test_r0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
